instr_fetch_stage: RTL and testbench
====================================

// Module: instr_fetch_stage
// PURPOSE
// - IF stage of the MIPS datapath: owns the PC register, fetches from instruction memory
//   over a req/ready handshake, and fills the IF/ID register consumed by decode.
// - Exports pc_plus4[31:28] as msb_pc4 to the jump-address former; takes back its 32-bit
//   jump address, plus branch and jr targets, as redirect sources. No delay slot.
// PARAMETERS
// - RESET_PC   32'h0000_0000   PC value loaded by reset
// PORTS
// - clk            in   1   single clock, all flops rising-edge
// - reset          in   1   synchronous, active-high
// - stall          in   1   decode cannot accept; hold IF/ID
// - redirect_valid in   1   decode redirects the PC this cycle
// - redirect_sel   in   2   01 branch, 10 jump, 11 jr (00 ignored = no redirect)
// - br_target      in  32   branch target (pc4 + sext(imm)<<2)
// - jump_addr      in  32   {msb_pc4, target26, 2'b00} from jump-address former
// - jr_target      in  32   rs register value
// - msb_pc4        out  4   if_id_pc4[31:28]
// - imem_req       out  1   fetch request
// - imem_addr      out 32   fetch address (= pc)
// - imem_ready     in   1   request complete this cycle; imem_rdata valid
// - imem_rdata     in  32   instruction word
// - if_id_valid    out  1   IF/ID holds a valid instruction
// - if_id_instr    out 32   fetched instruction
// - if_id_pc4      out 32   address of that instruction + 4
// BEHAVIOUR
// - Reset: pc=RESET_PC, state=START, imem_req=0, if_id_valid=0, if_id_instr=0,
//   if_id_pc4=0, skid empty. msb_pc4=0 follows.
// - FSM START -> BUSY unconditionally; imem_req=1 in BUSY and DRAIN, 0 in START/IDLE.
//   First request: 2nd cycle after reset deasserts.
// - Handshake: transfer when imem_req&&imem_ready. While req&&!ready, imem_addr and
//   imem_req held stable; a raised request is never withdrawn (not even by redirect).
// - BUSY + transfer, no redirect: word goes to IF/ID if IF/ID is empty or !stall, else to
//   1-entry skid buffer; pc<=pc+4 (mod 2^32, wraps FFFF_FFFC->0). Stay BUSY if the skid
//   is empty afterwards, else -> IDLE.
// - IDLE: skid drains into IF/ID when !stall; -> BUSY the cycle after skid is empty.
// - IF/ID advance: when !stall, IF/ID loads skid (if full) else the live transfer, else
//   if_id_valid<=0. Ordering preserved: skid always older than live response.
// - Throughput: imem_ready tied 1 and no stall -> one instruction per cycle.
// - Redirect (redirect_valid && sel!=00): pc<=selected target the same edge;
//   if_id_valid<=0 and skid cleared regardless of stall (redirect beats stall).
//   If a request is outstanding and not completing this cycle -> DRAIN; if completing this
//   cycle its word is dropped -> BUSY; if no request -> BUSY.
// - DRAIN: keep old address until ready; response discarded; -> BUSY (new pc).
//   A further redirect in DRAIN updates pc, stays DRAIN.
// - Target low bits are not checked; pc[1:0] carried as given.
// - Reset mid-request: state and outputs return to reset values next edge; memory side
//   must tolerate request withdrawal on reset only.
// STRUCTURE
// - Shared package mips_pkg: redirect_sel encodings (SEL_BR, SEL_J, SEL_JR), fetch FSM
//   state encodings, RESET_PC default, NOP word 32'h0000_0000.
// - One sub-module: fetch_skid_buf (1-entry instr+pc4 buffer, load/drain/flush).
// - Next-PC mux and pc+4 adder inline.
// TESTING
// - Reset, ready=1, no stall -> req rises cycle 2; imem_addr 0,4,8,...;
//   if_id_pc4 4,8,C on consecutive cycles.
// - stall held 3 cycles mid-stream -> one word in skid, req low, IF/ID frozen;
//   on release words emerge in order, no gaps or duplicates.
// - ready low 4 cycles with req high -> imem_addr stable all 4, if_id_valid drops then
//   resumes with the correct instruction.
// - Redirect sel=10, jump_addr=0040_0020 while a request is outstanding -> DRAIN,
//   stale word dropped, next req addr 0040_0020, if_id_valid=0 meanwhile.
// - Redirect sel=01 with stall=1 and skid full -> IF/ID and skid flushed;
//   next valid if_id_pc4 = br_target+4.
// - PC at FFFF_FFFC -> next address 0000_0000; msb_pc4 tracks if_id_pc4[31:28]
//   (0 after wrap).

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: redirect selects, fetch FSM encodings,
// reset PC default and the fetch entry carried through IF/ID and the skid.
package mips_pkg;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_BR   = 2'b01;
  localparam logic [1:0] SEL_J    = 2'b10;
  localparam logic [1:0] SEL_JR   = 2'b11;

  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_IDLE  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_entry_t;

  function automatic logic [31:0] redirect_target(
    input logic [1:0]  sel,
    input logic [31:0] br,
    input logic [31:0] jmp,
    input logic [31:0] jr
  );
    case (sel)
      SEL_J:   return jmp;
      SEL_JR:  return jr;
      default: return br;
    endcase
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry buffer holding a fetched word (and its pc+4) that IF/ID could not
// accept because decode was stalled. Flush wins over load, load over drain.
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_drain,
  input  logic         i_flush,
  input  fetch_entry_t i_entry,
  output logic         o_valid,
  output fetch_entry_t o_entry
);

  logic         r_valid;
  fetch_entry_t r_entry;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_entry <= '{instr: NOP_WORD, pc4: 32'h0};
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_entry <= i_entry;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;

endmodule

// File: rtl/instr_fetch_stage.sv
// MIPS IF stage: PC register, req/ready fetch FSM, IF/ID register with a
// one-entry skid for stalls, and branch/jump/jr redirects (no delay slot).
module instr_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_sel,
  input  logic [31:0] br_target,
  input  logic [31:0] jump_addr,
  input  logic [31:0] jr_target,
  output logic [3:0]  msb_pc4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4
);

  logic [1:0]   r_state;
  logic [1:0]   w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_drain_addr;
  logic         r_if_id_valid;
  fetch_entry_t r_if_id;

  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_target;
  logic         w_xfer;
  logic         w_redirect;
  logic         w_live;
  logic         w_if_id_adv;
  logic         w_skid_load;
  logic         w_skid_drain;
  logic         w_skid_valid;
  fetch_entry_t w_skid_entry;
  fetch_entry_t w_live_entry;

  // DRAIN keeps presenting the pre-redirect address until memory answers.
  assign imem_req   = (r_state == ST_BUSY) || (r_state == ST_DRAIN);
  assign imem_addr  = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;
  assign w_xfer     = imem_req && imem_ready;
  assign w_redirect = redirect_valid && (redirect_sel != SEL_NONE);
  assign w_live     = w_xfer && (r_state == ST_BUSY) && !w_redirect;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_target     = redirect_target(redirect_sel, br_target, jump_addr, jr_target);
  assign w_live_entry = '{instr: imem_rdata, pc4: w_pc_plus4};

  // The skid is only ever filled in BUSY, where it is known to be empty.
  assign w_if_id_adv  = !stall || !r_if_id_valid;
  assign w_skid_load  = w_live && !w_if_id_adv;
  assign w_skid_drain = w_skid_valid && w_if_id_adv && !w_redirect;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_flush (w_redirect),
    .i_entry (w_live_entry),
    .o_valid (w_skid_valid),
    .o_entry (w_skid_entry)
  );

  always_comb begin
    w_state_next = r_state;
    if (w_redirect) begin
      w_state_next = (imem_req && !imem_ready) ? ST_DRAIN : ST_BUSY;
    end else begin
      case (r_state)
        ST_START: w_state_next = ST_BUSY;
        ST_BUSY:  if (w_skid_load) w_state_next = ST_IDLE;
        ST_IDLE:  if (w_skid_drain) w_state_next = ST_BUSY;
        ST_DRAIN: if (imem_ready) w_state_next = ST_BUSY;
        default:  w_state_next = ST_START;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_START;
      r_pc          <= RESET_PC;
      r_drain_addr  <= RESET_PC;
      r_if_id_valid <= 1'b0;
      r_if_id       <= '{instr: NOP_WORD, pc4: 32'h0};
    end else begin
      r_state <= w_state_next;

      if (w_redirect) begin
        r_pc <= w_target;
      end else if (w_live) begin
        r_pc <= w_pc_plus4;
      end

      if (w_redirect && (r_state == ST_BUSY)) begin
        r_drain_addr <= r_pc;
      end

      // Redirect beats stall; otherwise the skid is always older than the live word.
      if (w_redirect) begin
        r_if_id_valid <= 1'b0;
      end else if (w_if_id_adv) begin
        if (w_skid_valid) begin
          r_if_id_valid <= 1'b1;
          r_if_id       <= w_skid_entry;
        end else if (w_live) begin
          r_if_id_valid <= 1'b1;
          r_if_id       <= w_live_entry;
        end else begin
          r_if_id_valid <= 1'b0;
        end
      end
    end
  end

  assign if_id_valid = r_if_id_valid;
  assign if_id_instr = r_if_id.instr;
  assign if_id_pc4   = r_if_id.pc4;
  assign msb_pc4     = r_if_id.pc4[31:28];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_instr_fetch_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [1:0]  redirect_sel = 2'b00;
  logic [31:0] br_target = 32'h0;
  logic [31:0] jump_addr = 32'h0;
  logic [31:0] jr_target = 32'h0;
  logic [3:0]  msb_pc4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  instr_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_sel   (redirect_sel),
    .br_target      (br_target),
    .jump_addr      (jump_addr),
    .jr_target      (jr_target),
    .msb_pc4        (msb_pc4),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc4      (if_id_pc4)
  );

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: words accepted but not yet consumed, in program order.
  // q[0] is what IF/ID must show; a second entry means the skid is occupied.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc = RESET_PC_DEFAULT;
  logic [31:0] m_drain = RESET_PC_DEFAULT;
  bit          m_draining = 1'b0;
  bit          m_rst = 1'b1;

  always @(negedge clk) begin
    logic exp_req;
    bit   xfer;
    bit   redir;
    exp_req = !m_rst && (q.size() < 2);
    chk1("imem_req", imem_req, exp_req);
    chk1("if_id_valid", if_id_valid, q.size() > 0);
    if (m_rst) begin
      chk32("reset_addr", imem_addr, RESET_PC_DEFAULT);
      chk32("reset_instr", if_id_instr, 32'h0);
      chk32("reset_pc4", if_id_pc4, 32'h0);
      chk32("reset_msb", 32'(msb_pc4), 32'h0);
    end
    if (exp_req) chk32("imem_addr", imem_addr, m_draining ? m_drain : m_pc);
    if (q.size() > 0) begin
      chk32("if_id_instr", if_id_instr, q[0].instr);
      chk32("if_id_pc4", if_id_pc4, q[0].pc4);
      chk32("msb_pc4", 32'(msb_pc4), 32'(q[0].pc4[31:28]));
    end

    if (reset) begin
      q.delete();
      m_pc       = RESET_PC_DEFAULT;
      m_drain    = RESET_PC_DEFAULT;
      m_draining = 1'b0;
      m_rst      = 1'b1;
    end else begin
      m_rst = 1'b0;
      xfer  = exp_req && imem_ready;
      redir = redirect_valid && (redirect_sel != 2'b00);
      if (verbose && xfer)
        $display("xfer addr=%h data=%h %s", imem_addr, imem_rdata,
                 (m_draining || redir) ? "dropped" : "kept");
      if (redir) begin
        q.delete();
        if (exp_req && !imem_ready) begin
          if (!m_draining) m_drain = m_pc;
          m_draining = 1'b1;
        end else begin
          m_draining = 1'b0;
        end
        m_pc = (redirect_sel == 2'b01) ? br_target :
               (redirect_sel == 2'b10) ? jump_addr : jr_target;
      end else begin
        if (!stall && q.size() > 0) void'(q.pop_front());
        if (xfer) begin
          if (m_draining) begin
            m_draining = 1'b0;
          end else begin
            q.push_back(ent_t'{instr: mem_word(m_pc), pc4: m_pc + 32'd4});
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    logic [31:0] a;
    logic [31:0] old;
    int          n;

    // Reset values and first fetches.
    repeat (3) tick();
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", if_id_valid, 1'b0);
    chk32("rst_pc4", if_id_pc4, 32'h0);
    chk32("rst_instr", if_id_instr, 32'h0);
    chk32("rst_msb", 32'(msb_pc4), 32'h0);
    reset = 1'b0;
    chk1("c1_req", imem_req, 1'b0);
    tick(); chk1("c2_req", imem_req, 1'b1); chk32("c2_addr", imem_addr, 32'h0);
    tick(); chk32("c3_addr", imem_addr, 32'h4); chk32("c3_pc4", if_id_pc4, 32'h4);
    tick(); chk32("c4_addr", imem_addr, 32'h8); chk32("c4_pc4", if_id_pc4, 32'h8);
    tick(); chk32("c5_pc4", if_id_pc4, 32'hC); chk32("c5_instr", if_id_instr, mem_word(32'h8));

    // Stall for three cycles: one word parks in the skid.
    p = if_id_pc4;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk32("stall_hold_pc4", if_id_pc4, p);
      chk1("stall_req_low", imem_req, 1'b0);
    end
    stall = 1'b0;
    tick(); chk32("release_pc4_1", if_id_pc4, p + 32'd4);
    tick(); chk32("release_pc4_2", if_id_pc4, p + 32'd8);

    // Memory not ready for four cycles.
    a = imem_addr;
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk32("rdy_low_addr", imem_addr, a);
      chk1("rdy_low_req", imem_req, 1'b1);
      chk1("rdy_low_valid", if_id_valid, 1'b0);
    end
    imem_ready = 1'b1;
    tick();
    chk1("rdy_resume_valid", if_id_valid, 1'b1);
    chk32("rdy_resume_pc4", if_id_pc4, a + 32'd4);
    chk32("rdy_resume_instr", if_id_instr, mem_word(a));

    // Jump while a request is outstanding.
    imem_ready = 1'b0;
    old = imem_addr;
    redirect_valid = 1'b1; redirect_sel = 2'b10; jump_addr = 32'h0040_0020;
    tick();
    redirect_valid = 1'b0;
    chk32("drain_addr", imem_addr, old);
    chk1("drain_req", imem_req, 1'b1);
    chk1("drain_valid", if_id_valid, 1'b0);
    tick(); chk32("drain_addr2", imem_addr, old);
    imem_ready = 1'b1;
    tick();
    chk32("jump_req_addr", imem_addr, 32'h0040_0020);
    chk1("jump_valid_low", if_id_valid, 1'b0);
    tick(); chk32("jump_pc4", if_id_pc4, 32'h0040_0024);

    // Branch while stalled with the skid full.
    stall = 1'b1;
    tick(); tick();
    chk1("skid_full_req", imem_req, 1'b0);
    redirect_valid = 1'b1; redirect_sel = 2'b01; br_target = 32'h0000_1000;
    tick();
    redirect_valid = 1'b0;
    chk1("flush_valid", if_id_valid, 1'b0);
    stall = 1'b0;
    n = 0;
    while (!if_id_valid && n < 10) begin
      tick();
      n++;
    end
    chk1("flush_wait", if_id_valid, 1'b1);
    chk32("flush_pc4", if_id_pc4, 32'h0000_1004);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_sel = 2'b11; jr_target = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    chk32("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    tick();
    chk32("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    chk32("wrap_pc4_1", if_id_pc4, 32'hFFFF_FFFC);
    chk32("wrap_msb_1", 32'(msb_pc4), 32'hF);
    tick();
    chk32("wrap_addr2", imem_addr, 32'h0000_0000);
    chk32("wrap_pc4_2", if_id_pc4, 32'h0000_0000);
    chk32("wrap_msb_2", 32'(msb_pc4), 32'h0);

    // Reset while a request is pending.
    imem_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk1("midrst_req", imem_req, 1'b0);
    chk1("midrst_valid", if_id_valid, 1'b0);
    chk32("midrst_addr", imem_addr, 32'h0);
    reset = 1'b0;
    imem_ready = 1'b1;

    // Randomized traffic; the model checks every cycle.
    verbose = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      stall          = ($urandom_range(0, 99) < 30);
      imem_ready     = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 8);
      redirect_sel   = 2'($urandom_range(0, 3));
      br_target      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      jump_addr      = {msb_pc4, 26'($urandom), 2'b00};
      jr_target      = $urandom;
      reset          = ($urandom_range(0, 999) < 5);
      tick();
    end
    stall = 1'b0; redirect_valid = 1'b0; reset = 1'b0; imem_ready = 1'b1;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
